pipelined_subtractor_14bit: RTL and testbench

- Elastic two-stage pipelined subtractor: diff = a - b on 14-bit unsigned operands, 15-bit two's-complement result.
- Companion and inverse of the team's pipelined 14-bit adder. Used to undo or compare adder outputs in the same datapath.
- Borrow chain split across two register stages (low half, then high half).
- Valid/ready handshakes on both sides, so it can sit between stalling producers and consumers.

---
 rtl/pipelined_subtractor_14bit_if.sv | 24 ++
 rtl/pipelined_subtractor_14bit.sv | 79 +++++++
 tb/tb_pipelined_subtractor_14bit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_14bit_if.sv
// Handshake and data bundle for the pipelined subtractor: operand side plus result side.
interface pipelined_subtractor_14bit_if #(
    parameter int unsigned WIDTH = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;
    logic             neg;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, neg, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, neg, zero
    );
endinterface

// File: rtl/pipelined_subtractor_14bit.sv
// Elastic two-stage subtractor: low-half borrow resolved in stage 1, high half in stage 2.
module pipelined_subtractor_14bit #(
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned LO_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_subtractor_14bit_if.slave bus
);
    localparam int unsigned HI_WIDTH = WIDTH - LO_WIDTH;
    localparam int unsigned HI_RW    = HI_WIDTH + 1;

    logic                v1;
    logic                v2;
    logic                e1;
    logic                e2;
    logic [LO_WIDTH-1:0] lo_q;
    logic                borrow_q;
    logic [HI_WIDTH-1:0] a_hi_q;
    logic [HI_WIDTH-1:0] b_hi_q;
    logic [WIDTH:0]      diff_q;
    logic                neg_q;
    logic                zero_q;

    logic [LO_WIDTH:0]   lo_c;
    logic [HI_WIDTH:0]   hi_c;
    logic [WIDTH:0]      diff_c;

    // Stage enables and the two half-width subtractions.
    always_comb begin
        e2     = !v2 || bus.out_ready;
        e1     = !v1 || e2;
        lo_c   = {1'b0, bus.a[LO_WIDTH-1:0]} - {1'b0, bus.b[LO_WIDTH-1:0]};
        hi_c   = {1'b0, a_hi_q} - {1'b0, b_hi_q} - HI_RW'(borrow_q);
        diff_c = {hi_c, lo_q};
    end

    // Stage 1: low half plus borrow; upper operand bits carried forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            lo_q     <= '0;
            borrow_q <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
        end else if (e1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                lo_q     <= lo_c[LO_WIDTH-1:0];
                borrow_q <= lo_c[LO_WIDTH];
                a_hi_q   <= bus.a[WIDTH-1:LO_WIDTH];
                b_hi_q   <= bus.b[WIDTH-1:LO_WIDTH];
            end
        end
    end

    // Stage 2: full result and flags; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            diff_q <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (e2) begin
            v2 <= v1;
            if (v1) begin
                diff_q <= diff_c;
                neg_q  <= diff_c[WIDTH];
                zero_q <= (diff_c == '0);
            end
        end
    end

    assign bus.in_ready  = e1;
    assign bus.out_valid = v2;
    assign bus.diff      = diff_q;
    assign bus.neg       = neg_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_subtractor_14bit.sv
// Directed and randomized checks of the pipelined subtractor against an arithmetic scoreboard.
module tb_pipelined_subtractor_14bit;
    localparam int unsigned W = 14;

    typedef struct {
        logic [W:0] d;
        logic       n;
        logic       z;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_subtractor_14bit_if #(.WIDTH(W)) bus ();

    pipelined_subtractor_14bit #(.WIDTH(W), .LO_WIDTH(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         delivered = 0;
    logic       last_acc;
    logic       prev_stall = 1'b0;
    logic [W:0] prev_diff;
    logic       prev_neg, prev_zero;
    logic       h_acc1 = 0, h_acc2 = 0, h_rdy1 = 0, h_rdy2 = 0, h_ordy1 = 0;
    logic       hist_ok1 = 0, hist_ok2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t r;
        r.d = 15'((a - b + 32768) % 32768);
        r.n = (a < b);
        r.z = (a == b);
        return r;
    endfunction

    // One clock slot: drive, settle, score transfers, then advance past the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ordy);
        logic otx;
        exp_t e;
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.out_ready = ordy;
        #1;
        last_acc = iv && bus.in_ready;
        otx      = bus.out_valid && ordy;
        chk("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < 2) || ordy));
        // Unstalled pipeline behaves as a pure two-slot delay.
        if (hist_ok2 && h_rdy2 && h_ordy1)
            chk("out_valid_flow", 32'(bus.out_valid), 32'(h_acc2));
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_diff", 32'(bus.diff), 32'(prev_diff));
            chk("stall_neg", 32'(bus.neg), 32'(prev_neg));
            chk("stall_zero", 32'(bus.zero), 32'(prev_zero));
        end
        if (otx) begin
            chk("spurious_out", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("diff", 32'(bus.diff), 32'(e.d));
                chk("neg", 32'(bus.neg), 32'(e.n));
                chk("zero", 32'(bus.zero), 32'(e.z));
                delivered++;
            end
        end
        if (last_acc) exp_q.push_back(model(int'(ia), int'(ib)));
        prev_stall = bus.out_valid && !ordy;
        prev_diff  = bus.diff;
        prev_neg   = bus.neg;
        prev_zero  = bus.zero;
        h_acc2 = h_acc1; h_acc1 = last_acc;
        h_rdy2 = h_rdy1; h_rdy1 = bus.in_ready;
        h_ordy1 = ordy;
        hist_ok2 = hist_ok1; hist_ok1 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        delivered  = 0;
        prev_stall = 1'b0;
        hist_ok1   = 1'b0;
        hist_ok2   = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_neg", 32'(bus.neg), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1);
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Single operation with expected constants checked when the result first appears.
    task automatic directed(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [W:0] d, input logic n, input logic z);
        cycle(1'b1, ia, ib, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        chk("dir_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_diff", 32'(bus.diff), 32'(d));
        chk("dir_neg", 32'(bus.neg), 32'(n));
        chk("dir_zero", 32'(bus.zero), 32'(z));
        drain();
    endtask

    initial begin
        logic [W-1:0] pa[4];
        logic [W-1:0] pb[4];
        int   k;
        logic saw_low;

        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        do_reset();

        directed(14'd100,   14'd30,     15'h0046, 1'b0, 1'b0);
        directed(14'd5,     14'd9,      15'h7FFC, 1'b1, 1'b0);
        directed(14'd0,     14'h3FFF,   15'h4001, 1'b1, 1'b0);
        directed(14'h1234,  14'h1234,   15'h0000, 1'b0, 1'b1);
        directed(14'h0080,  14'h0001,   15'h007F, 1'b0, 1'b0);
        directed(14'h3F80,  14'h007F,   15'h3F01, 1'b0, 1'b0);
        directed(14'h3FFF,  14'h0000,   15'h3FFF, 1'b0, 1'b0);

        // Back-to-back random stream at full throughput.
        for (int i = 0; i < 8; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b1);
        chk("stream_queued", 32'(exp_q.size()), 32'd2);
        drain();

        // Backpressure: consumer stalls for 3 slots once the first result is valid.
        for (int i = 0; i < 4; i++) begin pa[i] = W'($urandom); pb[i] = W'($urandom); end
        k = 0;
        saw_low = 1'b0;
        for (int t = 0; t < 30 && k < 4; t++) begin
            cycle(1'b1, pa[k], pb[k], !(t >= 2 && t <= 4));
            if (!last_acc) saw_low = 1'b1;
            if (last_acc) k++;
        end
        chk("bp_all_accepted", 32'(k), 32'd4);
        chk("bp_ready_dropped", 32'(saw_low), 32'd1);
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 2) != 0));
        drain();

        // Reset mid-flight discards everything in the pipe.
        cycle(1'b1, 14'd1000, 14'd1, 1'b1);
        cycle(1'b1, 14'd2000, 14'd2, 1'b1);
        do_reset();
        cycle(1'b1, 14'd7, 14'd2, 1'b1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, '0, '0, 1'b1);
        chk("post_rst_diff", 32'(bus.diff), 32'h5);
        drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
        chk("post_rst_count", 32'(delivered), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
